// File: rtl/icache.sv
// Direct-mapped instruction cache, one word per line, with fence.i sweep.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache #(
  parameter int INDEX_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_i,
  input  logic [31:0] read_addr_i,
  output logic        read_hit_o,
  output logic [31:0] read_inst_o,
  input  logic        write_i,
  input  logic [31:0] write_addr_i,
  input  logic [31:0] write_inst_i,
  input  logic        flush_i,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
`endif
  output logic        busy_o
);

  localparam int TAG_BITS = 32 - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t state_q, state_d;
  logic [INDEX_BITS-1:0] cnt_q, cnt_d;
  logic sweep_clr;
  logic fill;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES];

  logic [INDEX_BITS-1:0] r_idx, w_idx;
  logic [TAG_BITS-1:0]   r_tag, w_tag;
  logic arr_hit, fwd;
  logic unused;

  assign r_idx = read_addr_i[INDEX_BITS+1:2];
  assign r_tag = read_addr_i[31:INDEX_BITS+2];
  assign w_idx = write_addr_i[INDEX_BITS+1:2];
  assign w_tag = write_addr_i[31:INDEX_BITS+2];
  assign unused = ^{read_addr_i[1:0], write_addr_i[1:0]};

  assign busy_o = (state_q == SWEEP);
  assign fill   = write_i && !busy_o && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sweep_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        sweep_clr = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == {INDEX_BITS{1'b1}})
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      valid <= '0;
    else if (sweep_clr)
      valid[cnt_q] <= 1'b0;
    else if (fill)
      valid[w_idx] <= 1'b1;
  end

  // Tag/data need no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[w_idx] <= w_tag;
      data[w_idx] <= write_inst_i;
    end
  end

  assign arr_hit = valid[r_idx] && (tags[r_idx] == r_tag);
  assign fwd = write_i && (write_addr_i[31:2] == read_addr_i[31:2]);

  always_comb begin
    read_hit_o  = 1'b0;
    read_inst_o = 32'h0;
    if (read_i && !busy_o && !rst) begin
      if (fwd) begin
        read_hit_o  = 1'b1;
        read_inst_o = write_inst_i;
      end else if (arr_hit) begin
        read_hit_o  = 1'b1;
        read_inst_o = data[r_idx];
      end
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (read_i && !busy_o) begin
      if (read_hit_o) begin
        if (hit_cnt_o != 32'hFFFF_FFFF)
          hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        if (miss_cnt_o != 32'hFFFF_FFFF)
          miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache against a word-addressed reference model.
// Covers fills, forwarding, replacement, flush sweep and reset mid-sweep.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        read_i;
  logic [31:0] read_addr_i;
  logic        read_hit_o;
  logic [31:0] read_inst_o;
  logic        write_i;
  logic [31:0] write_addr_i;
  logic [31:0] write_inst_i;
  logic        flush_i;
  logic        busy_o;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  icache dut (
    .clk          (clk),
    .rst          (rst),
    .read_i       (read_i),
    .read_addr_i  (read_addr_i),
    .read_hit_o   (read_hit_o),
    .read_inst_o  (read_inst_o),
    .write_i      (write_i),
    .write_addr_i (write_addr_i),
    .write_inst_i (write_inst_i),
    .flush_i      (flush_i),
`ifdef ICACHE_STATS_EN
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o),
`endif
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int LINES = 128;

  // Model: per line, the word address held (addr[31:2]) and its data.
  bit          mv [LINES];
  logic [29:0] mw [LINES];
  logic [31:0] md [LINES];
  int          sweep_left;
  int          mhits;
  int          mmiss;

  int total;
  int passes;
  int fails;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) mv[i] = 0;
  endtask

  task automatic cyc(input logic r, input logic [31:0] ra,
                     input logic w, input logic [31:0] wa,
                     input logic [31:0] wd, input logic f,
                     input logic rs, input bit chk);
    int   idx;
    bit   arr;
    bit   fw;
    bit   eh;
    logic [31:0] ei;
    read_i       = r;
    read_addr_i  = ra;
    write_i      = w;
    write_addr_i = wa;
    write_inst_i = wd;
    flush_i      = f;
    rst          = rs;
    @(negedge clk);
    idx = int'(ra[8:2]);
    arr = mv[idx] && (mw[idx] == ra[31:2]);
    fw  = w && (wa[31:2] == ra[31:2]);
    eh  = r && !rs && (sweep_left == 0) && (arr || fw);
    ei  = !eh ? 32'h0 : (fw ? wd : md[idx]);
    if (chk) begin
      check("hit", {31'b0, read_hit_o}, {31'b0, eh});
      check("inst", read_inst_o, ei);
      check("busy", {31'b0, busy_o}, {31'b0, sweep_left > 0});
`ifdef ICACHE_STATS_EN
      check("hit_cnt", hit_cnt_o, mhits);
      check("miss_cnt", miss_cnt_o, mmiss);
`endif
    end
    if (rs) begin
      clear_model();
      sweep_left = 0;
      mhits = 0;
      mmiss = 0;
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else begin
      if (r) begin
        if (eh) mhits++;
        else mmiss++;
      end
      if (f) begin
        clear_model();
        sweep_left = LINES;
      end else if (w) begin
        idx = int'(wa[8:2]);
        mv[idx] = 1;
        mw[idx] = wa[31:2];
        md[idx] = wd;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1, a, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(0, 0, 1, a, d, 0, 0, 1);
  endtask

  initial begin
    int n;
    logic [31:0] ra, wa;
    total = 0;
    passes = 0;
    fails = 0;
    sweep_left = 0;
    mhits = 0;
    mmiss = 0;
    clear_model();
    rst = 1;
    read_i = 0;
    read_addr_i = 0;
    write_i = 0;
    write_addr_i = 0;
    write_inst_i = 0;
    flush_i = 0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    rd(32'h0000_0000);

    wr(32'h0000_0004, 32'h0050_0093);
    rd(32'h0000_0004);
    rd(32'h0000_0204);

    cyc(1, 32'h10, 1, 32'h10, 32'h00A0_0113, 0, 0, 1);
    cyc(1, 32'h210, 1, 32'h10, 32'h00A0_0113, 0, 0, 1);

    wr(32'h0000_0204, 32'hDEAD_BEEF);
    rd(32'h0000_0004);
    rd(32'h0000_0204);

    for (int k = 0; k < 200; k++) begin
      ra = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2)
           | $urandom_range(0, 3);
      wa = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2)
           | $urandom_range(0, 3);
      cyc(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
          $urandom, 0, 0, 1);
    end

    wr(32'h0000_0040, 32'h1111_1111);
    wr(32'h0000_0044, 32'h2222_2222);
    wr(32'h0000_0048, 32'h3333_3333);
    cyc(1, 32'h40, 0, 0, 0, 1, 0, 1);
    n = 0;
    for (int k = 0; k < 200 && busy_o; k++) begin
      n++;
      cyc(1, 32'h44, n == 10, 32'h4C, 32'h4444_4444, n == 50, 0, 1);
    end
    check("sweep_len", n, 128);
    rd(32'h0000_0040);
    rd(32'h0000_0044);
    rd(32'h0000_0048);
    rd(32'h0000_004C);

    wr(32'h0000_0080, 32'h5555_5555);
    cyc(0, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 40; k++) rd(32'h80);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    check("busy_after_rst", {31'b0, busy_o}, 32'h0);
    rd(32'h0000_0080);
    wr(32'h0000_0080, 32'h6666_6666);
    rd(32'h0000_0080);

`ifdef ICACHE_STATS_EN
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    wr(32'h0000_0004, 32'h0050_0093);
    rd(32'h0000_0004);
    rd(32'h0000_0004);
    rd(32'h0000_0008);
    rd(32'h0000_000C);
    rd(32'h0000_0204);
    check("stat_hits", hit_cnt_o, 32'd2);
    check("stat_miss", miss_cnt_o, 32'd3);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    check("stat_hits_rst", hit_cnt_o, 32'd0);
    check("stat_miss_rst", miss_cnt_o, 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
